// File: rtl/jtcontra_mathbus.sv
// jtcontra_mathbus: CPU-side bus front end for the Konami multiplier/divider.
// Decodes an 8-byte window at BASE, turns each CPU access into a single-clock
// register strobe towards the math unit, and holds the CPU through rdy while
// the multiplier or divider results are still settling.
//
// Ports:
//   rst, clk       asynchronous active-high reset, system clock
//   cpu_cen        one-clk pulse marking the start of every CPU access
//   cpu_addr       CPU address
//   cpu_rnw        1 = read, 0 = write
//   cpu_vma        CPU address valid
//   cpu_dout       CPU write data
//   cpu_din        registered read data returned to the CPU
//   rdy            combinational ready, low stretches the current CPU cycle
//   math_cs        registered one-clk strobe to the math unit
//   math_wrn       registered, 0 marks a write strobe
//   math_addr      registered math register index
//   math_din       registered write data to the math unit
//   math_dout      math unit read data, valid one clk after a read strobe
module jtcontra_mathbus #(
  parameter logic [15:0] BASE    = 16'h0010,
  parameter int unsigned DIV_LAT = 19,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cpu_cen,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic        cpu_vma,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy,
  output logic        math_cs,
  output logic        math_wrn,
  output logic [2:0]  math_addr,
  output logic [7:0]  math_din,
  input  logic [7:0]  math_dout
);

  localparam int unsigned DIV_W = (DIV_LAT > 1) ? $clog2(DIV_LAT + 1) : 1;
  localparam int unsigned MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RD2  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [MUL_W-1:0] mul_cnt;
  logic             served;

  logic       hit;
  logic [2:0] idx;
  logic       pending;
  logic       idx_lo;   // product registers 0..1
  logic       idx_mid;  // divider registers 2..5
  logic       div_busy;
  logic       mul_busy;
  logic       stall;

  // Address decode and stall qualification for the access on the bus
  always_comb begin
    hit      = cpu_vma && (cpu_addr[15:3] == BASE[15:3]);
    idx      = cpu_addr[2:0];
    pending  = hit && !served;
    idx_lo   = (idx[2:1] == 2'b00);
    idx_mid  = !idx_lo && (idx[2:1] != 2'b11);
    div_busy = (div_cnt != '0);
    mul_busy = (mul_cnt != '0);
    stall    = 1'b0;
    if (!cpu_rnw) begin
      stall = idx_mid && div_busy;
    end else begin
      if (idx_lo)  stall = mul_busy || div_busy;
      if (idx_mid) stall = div_busy;
    end
  end

  assign rdy = !pending || (state == DONE);

  // Access sequencer, latency counters and served flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      math_cs   <= 1'b0;
      math_wrn  <= 1'b1;
      math_addr <= 3'd0;
      math_din  <= 8'd0;
      cpu_din   <= 8'hFF;
      div_cnt   <= '0;
      mul_cnt   <= '0;
      served    <= 1'b0;
    end else begin
      // A new cpu_cen wins over completion so an access starting during DONE is not lost
      if (cpu_cen || !hit) begin
        served <= 1'b0;
      end else if (state == DONE) begin
        served <= 1'b1;
      end

      // Only the register-5 write starts a division; register 4 does not
      if (state == WR && math_addr == 3'd5) begin
        div_cnt <= DIV_W'(DIV_LAT);
      end else if (div_busy) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end

      if (state == WR && math_addr[2:1] == 2'b00) begin
        mul_cnt <= MUL_W'(MUL_LAT);
      end else if (mul_busy) begin
        mul_cnt <= mul_cnt - MUL_W'(1);
      end

      case (state)
        IDLE: begin
          if (pending && !stall) begin
            if (!cpu_rnw) begin
              math_cs   <= 1'b1;
              math_wrn  <= 1'b0;
              math_addr <= idx;
              math_din  <= cpu_dout;
              state     <= WR;
            end else if (idx[2:1] != 2'b11) begin
              math_cs   <= 1'b1;
              math_wrn  <= 1'b1;
              math_addr <= idx;
              state     <= RD;
            end else begin
              // Registers 6..7 are unmapped in the math unit
              cpu_din <= 8'hFF;
              state   <= DONE;
            end
          end
        end
        WR: begin
          math_cs  <= 1'b0;
          math_wrn <= 1'b1;
          state    <= DONE;
        end
        RD: begin
          math_cs <= 1'b0;
          state   <= RD2;
        end
        RD2: begin
          cpu_din <= math_dout;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
